// File: rtl/mem_load_forward_unit.sv
// mem_load_forward_unit
//   Load-side forwarding for the execute stage. Detects a load in EX/MEM whose
//   destination (single register or low/high pair) feeds an operand of the
//   instruction in ID/EX. It stalls the front end until data memory answers,
//   then replays the returned lanes onto the execute operand muxes for one
//   cycle. If memory never answers within MAX_LOAD_LATENCY cycles, the stall
//   is released and a sticky load_timeout error is raised.
//
// Ports
//   clock, reset_n            rising-edge clock, async active-low reset
//   ex_mem_*                  load in EX/MEM: valid flag, pair flag, dests
//   id_ex_src_{a,b}[_used]    operand source registers and read enables
//   mem_rd_valid/_data_*      data memory read response (two lanes)
//   stall, bubble             hold PC/IF/ID/ID-EX, insert NOP into EX/MEM
//   fwd_sel_{a,b}             00 normal, 01 replay low, 10 replay high
//   fwd_data_{low,high}       replay buffer (last captured read data)
//   load_timeout              sticky error flag
module mem_load_forward_unit #(
  parameter int unsigned DATA_WIDTH       = 8,
  parameter int unsigned ADDR_WIDTH       = 5,
  parameter int unsigned MAX_LOAD_LATENCY = 3
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  ex_mem_load,
  input  logic                  ex_mem_pair,
  input  logic [ADDR_WIDTH-1:0] ex_mem_dest_low,
  input  logic [ADDR_WIDTH-1:0] ex_mem_dest_high,
  input  logic [ADDR_WIDTH-1:0] id_ex_src_a,
  input  logic [ADDR_WIDTH-1:0] id_ex_src_b,
  input  logic                  id_ex_src_a_used,
  input  logic                  id_ex_src_b_used,
  input  logic                  mem_rd_valid,
  input  logic [DATA_WIDTH-1:0] mem_rd_data_low,
  input  logic [DATA_WIDTH-1:0] mem_rd_data_high,
  output logic                  stall,
  output logic                  bubble,
  output logic [1:0]            fwd_sel_a,
  output logic [1:0]            fwd_sel_b,
  output logic [DATA_WIDTH-1:0] fwd_data_low,
  output logic [DATA_WIDTH-1:0] fwd_data_high,
  output logic                  load_timeout
);

  localparam int unsigned CNT_W = $clog2(MAX_LOAD_LATENCY) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_LOAD_LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_MEM,
    REPLAY
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] trk_low_q, trk_high_q;
  logic                  trk_pair_q;
  logic [CNT_W-1:0]      cnt_q;
  logic [DATA_WIDTH-1:0] buf_low_q, buf_high_q;
  logic                  timeout_q;

  logic                  hazard;
  logic                  match_a, match_b;
  logic                  stall_c;
  logic [1:0]            sel_a_c, sel_b_c;
  logic                  do_latch, do_capture, do_inc, do_timeout;

  // Load-use hazard against the current EX/MEM contents.
  always_comb begin
    match_a = (id_ex_src_a == ex_mem_dest_low) ||
              (ex_mem_pair && (id_ex_src_a == ex_mem_dest_high));
    match_b = (id_ex_src_b == ex_mem_dest_low) ||
              (ex_mem_pair && (id_ex_src_b == ex_mem_dest_high));
    hazard  = ex_mem_load &&
              ((id_ex_src_a_used && match_a) || (id_ex_src_b_used && match_b));
  end

  // Replay select for one operand; low lane wins when low == high.
  function automatic logic [1:0] replay_sel(input logic [ADDR_WIDTH-1:0] src,
                                            input logic                  used);
    logic [1:0] sel;
    sel = 2'b00;
    if (used) begin
      if (src == trk_low_q)
        sel = 2'b01;
      else if (trk_pair_q && (src == trk_high_q))
        sel = 2'b10;
    end
    return sel;
  endfunction

  always_comb begin
    state_d    = state_q;
    stall_c    = 1'b0;
    sel_a_c    = 2'b00;
    sel_b_c    = 2'b00;
    do_latch   = 1'b0;
    do_capture = 1'b0;
    do_inc     = 1'b0;
    do_timeout = 1'b0;
    case (state_q)
      IDLE: begin
        stall_c = hazard;
        if (hazard) begin
          do_latch = 1'b1;
          state_d  = WAIT_MEM;
        end
      end
      WAIT_MEM: begin
        stall_c = 1'b1;
        if (mem_rd_valid) begin
          do_capture = 1'b1;
          state_d    = REPLAY;
        end else if (cnt_q == CNT_LAST) begin
          do_timeout = 1'b1;
          state_d    = IDLE;
        end else begin
          do_inc = 1'b1;
        end
      end
      REPLAY: begin
        sel_a_c = replay_sel(id_ex_src_a, id_ex_src_a_used);
        sel_b_c = replay_sel(id_ex_src_b, id_ex_src_b_used);
        stall_c = hazard;
        if (hazard) begin
          do_latch = 1'b1;
          state_d  = WAIT_MEM;
        end else begin
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      trk_low_q  <= '0;
      trk_high_q <= '0;
      trk_pair_q <= 1'b0;
      cnt_q      <= '0;
      buf_low_q  <= '0;
      buf_high_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (do_latch) begin
        trk_low_q  <= ex_mem_dest_low;
        trk_high_q <= ex_mem_dest_high;
        trk_pair_q <= ex_mem_pair;
        cnt_q      <= '0;
      end else if (do_inc) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
      if (do_capture) begin
        buf_low_q  <= mem_rd_data_low;
        buf_high_q <= mem_rd_data_high;
      end
      if (do_timeout)
        timeout_q <= 1'b1;
    end
  end

  // IDLE still decodes the hazard while reset is held, so the stall is gated
  // with reset_n to keep it low for the whole reset window.
  assign stall         = reset_n & stall_c;
  assign bubble        = reset_n & stall_c;
  assign fwd_sel_a     = sel_a_c;
  assign fwd_sel_b     = sel_b_c;
  assign fwd_data_low  = buf_low_q;
  assign fwd_data_high = buf_high_q;
  assign load_timeout  = timeout_q;

endmodule
